// File: rtl/auth_resp_tx_serializer_pkg.sv
// Shared types for the auth response serializer: one-hot states,
// byte counts and the 16-bit little-endian byte-order helper.
package auth_tx_pkg;

    localparam int HEADER_BYTES = 4;
    localparam int SETUP_BYTES  = 8;

    typedef enum logic [6:0] {
        S_IDLE     = 7'b0000001,
        S_LATCH    = 7'b0000010,
        S_SETUP    = 7'b0000100,
        S_DATA     = 7'b0001000,
        S_DONE     = 7'b0010000,
        S_ERR      = 7'b0100000,
        S_WAIT_LOW = 7'b1000000
    } state_t;

    // USB setup fields travel LSByte first on the wire
    function automatic logic [15:0] le16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

endpackage

// File: rtl/auth_resp_tx_serializer_if.sv
// Responder-side request bundle plus byte stream toward the USB endpoint.
// master = responder/sink environment, slave = serializer.
interface auth_resp_tx_serializer_if #(
    parameter int MAX_MSG_BYTES = 264,
    parameter int CNT_W         = 32
);
    localparam int PAY_W = (MAX_MSG_BYTES - auth_tx_pkg::HEADER_BYTES) * 8;

    logic             msg_req;
    logic [31:0]      header;
    logic [PAY_W-1:0] payload;
    logic [7:0]       bmRequestType;
    logic [7:0]       bRequest;
    logic [15:0]      wLength;
    logic [CNT_W-1:0] current_timeout;
    logic [1:0]       slot;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;
    logic             Ack_out;
    logic             timeout_err;
    logic             length_err;

    modport master (
        output msg_req, header, payload, bmRequestType, bRequest,
        output wLength, current_timeout, slot, tx_ready,
        input  tx_data, tx_valid, tx_last, Ack_out,
        input  timeout_err, length_err
    );

    modport slave (
        input  msg_req, header, payload, bmRequestType, bRequest,
        input  wLength, current_timeout, slot, tx_ready,
        output tx_data, tx_valid, tx_last, Ack_out,
        output timeout_err, length_err
    );

endinterface

// File: rtl/auth_tx_timeout_counter.sv
// Transfer watchdog: counts enabled cycles since clear; expired marks the
// cycle whose count reaches limit. A limit of zero never expires.
module auth_tx_timeout_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_inc;
        end
    end

    assign expired = enable && (limit != '0) && (cnt_inc == limit);

endmodule

// File: rtl/auth_resp_tx_serializer.sv
// Latches one auth response and streams it byte-wise to the USB data stage.
// Define AUTH_TX_SETUP_EN to prefix the 8-byte USB setup packet.
module auth_resp_tx_serializer
    import auth_tx_pkg::*;
#(
    parameter int MAX_MSG_BYTES = 264,
    parameter int CNT_W         = 32
) (
    input  logic clk,
    input  logic reset,
    auth_resp_tx_serializer_if.slave bus
);

    localparam int MSG_W = MAX_MSG_BYTES * 8;
    localparam int BC_W  = $clog2(MAX_MSG_BYTES + 1);

    state_t           state_q;
    state_t           state_d;
    logic [MSG_W-1:0] sr_q;
    logic [BC_W-1:0]  bc_q;
    logic [15:0]      wlen_q;
    logic [CNT_W-1:0] limit_q;
    logic             err_tmo_q;

    logic       len_bad;
    logic       hs;
    logic       last_hs;
    logic       expired;
    logic       tmo_clr;
    logic       tmo_en;
    logic       setup_end;
    logic [7:0] setup_byte;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       ack;
    logic       tmo_err;
    logic       len_err;

    assign len_bad = (wlen_q < 16'(HEADER_BYTES))
                  || (wlen_q > 16'(MAX_MSG_BYTES));
    assign hs      = tx_valid && bus.tx_ready;
    assign last_hs = hs && (bc_q == BC_W'(1));
    assign tmo_clr = (state_q == S_LATCH);
    assign tmo_en  = (state_q == S_SETUP) || (state_q == S_DATA);

`ifdef AUTH_TX_SETUP_EN
    localparam state_t AFTER_LATCH = S_SETUP;

    logic [SETUP_BYTES*8-1:0] setup_q;
    logic [2:0]               sidx_q;

    assign setup_end  = hs && (sidx_q == 3'(SETUP_BYTES - 1));
    assign setup_byte = setup_q[SETUP_BYTES*8-1 -: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            setup_q <= '0;
            sidx_q  <= '0;
        end else if (state_q == S_IDLE && bus.msg_req) begin
            setup_q <= {bus.bmRequestType, bus.bRequest,
                        le16(16'h0000),
                        le16({14'b0, bus.slot}),
                        le16(bus.wLength)};
            sidx_q  <= '0;
        end else if (state_q == S_SETUP && hs) begin
            setup_q <= setup_q << 8;
            sidx_q  <= sidx_q + 3'd1;
        end
    end
`else
    localparam state_t AFTER_LATCH = S_DATA;

    logic unused_setup_fields;

    assign unused_setup_fields = ^{bus.slot, bus.bmRequestType,
                                   bus.bRequest};
    assign setup_end  = 1'b0;
    assign setup_byte = 8'h00;
`endif

    auth_tx_timeout_counter #(
        .CNT_W (CNT_W)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clr),
        .enable  (tmo_en),
        .limit   (limit_q),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Finishing the last byte takes priority over a same-cycle expiry
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (bus.msg_req) state_d = S_LATCH;
            S_LATCH:    state_d = len_bad ? S_ERR : AFTER_LATCH;
            S_SETUP: begin
                if (expired)        state_d = S_ERR;
                else if (setup_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (last_hs)      state_d = S_DONE;
                else if (expired) state_d = S_ERR;
            end
            S_DONE:     state_d = S_WAIT_LOW;
            S_ERR:      state_d = S_WAIT_LOW;
            S_WAIT_LOW: if (!bus.msg_req) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q      <= '0;
            bc_q      <= '0;
            wlen_q    <= '0;
            limit_q   <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.msg_req) begin
                        sr_q    <= {bus.header, bus.payload};
                        wlen_q  <= bus.wLength;
                        limit_q <= bus.current_timeout;
                    end
                end
                S_LATCH: bc_q <= wlen_q[BC_W-1:0];
                S_DATA: begin
                    if (hs) begin
                        sr_q <= sr_q << 8;
                        bc_q <= bc_q - BC_W'(1);
                    end
                end
                default: ;
            endcase
            if (state_d == S_ERR && state_q != S_ERR) begin
                err_tmo_q <= (state_q != S_LATCH);
            end
        end
    end

    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        ack      = 1'b0;
        tmo_err  = 1'b0;
        len_err  = 1'b0;
        unique case (state_q)
            S_SETUP: begin
                tx_valid = 1'b1;
                tx_data  = setup_byte;
            end
            S_DATA: begin
                tx_valid = 1'b1;
                tx_data  = sr_q[MSG_W-1 -: 8];
                tx_last  = (bc_q == BC_W'(1));
            end
            S_DONE: ack = 1'b1;
            S_ERR: begin
                tmo_err = err_tmo_q;
                len_err = !err_tmo_q;
            end
            default: ;
        endcase
    end

    assign bus.tx_data     = tx_data;
    assign bus.tx_valid    = tx_valid;
    assign bus.tx_last     = tx_last;
    assign bus.Ack_out     = ack;
    assign bus.timeout_err = tmo_err;
    assign bus.length_err  = len_err;

endmodule

// File: tb/tb_auth_resp_tx_serializer.sv
// Directed bench for auth_resp_tx_serializer; honours AUTH_TX_SETUP_EN
// by expecting the 8-byte setup prefix ahead of every data stage.
module tb_auth_resp_tx_serializer;

    localparam int MAXB  = 264;
    localparam int CW    = 32;
    localparam int PAYW  = (MAXB - 4) * 8;
`ifdef AUTH_TX_SETUP_EN
    localparam int SOFF = 8;
`else
    localparam int SOFF = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    auth_resp_tx_serializer_if #(
        .MAX_MSG_BYTES (MAXB),
        .CNT_W         (CW)
    ) bus ();

    auth_resp_tx_serializer #(
        .MAX_MSG_BYTES (MAXB),
        .CNT_W         (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] got[$];
    logic [7:0] expq[$];
    int valid_cnt, first_valid, last_cnt, last_pos, last_cycle;
    int ack_cnt, ack_cycle, tmo_cnt, tmo_cycle, len_cnt, stall_bad;
    bit finished;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i, input logic [7:0] seed);
        return 8'(i * 13 + 5) ^ seed;
    endfunction

    function automatic logic [12:0] outs();
        return {bus.tx_data, bus.tx_valid, bus.tx_last, bus.Ack_out,
                bus.timeout_err, bus.length_err};
    endfunction

    task automatic start_req(input logic [31:0] hdr, input logic [15:0] wl,
                             input logic [31:0] tmo, input logic [7:0] seed);
        logic [PAYW-1:0] p;
        for (int i = 0; i < MAXB - 4; i++) begin
            p[(MAXB - 5 - i) * 8 +: 8] = pat(i, seed);
        end
        expq.delete();
        if (wl >= 16'd4 && wl <= 16'(MAXB)) begin
            if (SOFF != 0) begin
                expq.push_back(bus.bmRequestType);
                expq.push_back(bus.bRequest);
                expq.push_back(8'h00);
                expq.push_back(8'h00);
                expq.push_back({6'b0, bus.slot});
                expq.push_back(8'h00);
                expq.push_back(wl[7:0]);
                expq.push_back(wl[15:8]);
            end
            for (int j = 0; j < int'(wl); j++) begin
                if (j < 4) expq.push_back(hdr[(3 - j) * 8 +: 8]);
                else       expq.push_back(pat(j - 4, seed));
            end
        end
        @(negedge clk);
        bus.header          = hdr;
        bus.wLength         = wl;
        bus.current_timeout = tmo;
        bus.payload         = p;
        bus.msg_req         = 1'b1;
    endtask

    // mode 0: ready always, 1: ready on odd cycles, 2: never ready
    task automatic run(input int mode, input int maxc, input int abort_after);
        int  tail = 0;
        bit  term = 0;
        bit  stall_pend = 0;
        logic [7:0] sdata = 8'h00;
        got.delete();
        valid_cnt = 0; first_valid = -1; last_cnt = 0; last_pos = -1;
        last_cycle = -1; ack_cnt = 0; ack_cycle = -1; tmo_cnt = 0;
        tmo_cycle = -1; len_cnt = 0; stall_bad = 0; finished = 0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            case (mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = (c % 2 == 1);
                default: bus.tx_ready = 1'b0;
            endcase
            if (stall_pend) begin
                if (!bus.tx_valid || bus.tx_data !== sdata) stall_bad++;
                stall_pend = 0;
            end
            if (bus.tx_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = c;
                if (bus.tx_ready) begin
                    got.push_back(bus.tx_data);
                    if (bus.tx_last) begin
                        last_cnt++;
                        last_pos = got.size();
                        last_cycle = c;
                    end
                end else begin
                    stall_pend = 1;
                    sdata = bus.tx_data;
                end
            end
            if (bus.Ack_out)     begin ack_cnt++; ack_cycle = c; end
            if (bus.timeout_err) begin tmo_cnt++; tmo_cycle = c; end
            if (bus.length_err)  len_cnt++;
            if (bus.Ack_out || bus.timeout_err || bus.length_err) term = 1;
            if (term) begin
                tail++;
                if (tail >= 4) begin finished = 1; break; end
            end
            if (abort_after > 0 && got.size() == abort_after) begin
                finished = 1;
                break;
            end
        end
    endtask

    task automatic end_req();
        @(negedge clk);
        bus.msg_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        int bad = 0;
        int n;
        n = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            if (got[i] !== expq[i]) bad++;
        end
        chk({tag, "_done"}, 64'(finished), 64'd1);
        chk({tag, "_count"}, 64'(got.size()), 64'(expq.size()));
        chk({tag, "_bytes_bad"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int v;
        bus.msg_req = 1'b0;
        bus.header = '0;
        bus.payload = '0;
        bus.bmRequestType = 8'h80;
        bus.bRequest = 8'd24;
        bus.wLength = '0;
        bus.current_timeout = '0;
        bus.slot = 2'd2;
        bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'(outs()), 64'd0);
        reset = 1'b0;

        // 36 bytes, sink always ready
        start_req(32'h01830000, 16'd36, 32'd0, 8'h00);
        run(0, 400, 0);
        check_stream("t1");
        chk("t1_first_byte", 64'(got[SOFF]), 64'h01);
        chk("t1_second_byte", 64'(got[SOFF + 1]), 64'h83);
        chk("t1_first_valid", 64'(first_valid), 64'd2);
        chk("t1_last_cnt", 64'(last_cnt), 64'd1);
        chk("t1_last_pos", 64'(last_pos), 64'(36 + SOFF));
        chk("t1_ack_cnt", 64'(ack_cnt), 64'd1);
        chk("t1_ack_delay", 64'(ack_cycle - last_cycle), 64'd1);
        chk("t1_tmo_cnt", 64'(tmo_cnt), 64'd0);
        end_req();

        // 8 bytes, ready toggling each cycle
        start_req(32'h01840102, 16'd8, 32'd0, 8'h5a);
        run(1, 400, 0);
        check_stream("t2");
        chk("t2_stall_bad", 64'(stall_bad), 64'd0);
        chk("t2_last_pos", 64'(last_pos), 64'(8 + SOFF));
        chk("t2_ack_cnt", 64'(ack_cnt), 64'd1);
        end_req();

        // timeout of 5 cycles with a stalled sink
        start_req(32'h01810000, 16'd16, 32'd5, 8'h33);
        run(2, 100, 0);
        chk("t3_done", 64'(finished), 64'd1);
        chk("t3_valid_cycles", 64'(valid_cnt), 64'd5);
        chk("t3_tmo_cnt", 64'(tmo_cnt), 64'd1);
        chk("t3_tmo_cycle", 64'(tmo_cycle), 64'd7);
        chk("t3_ack_cnt", 64'(ack_cnt), 64'd0);
        chk("t3_no_bytes", 64'(got.size()), 64'd0);
        v = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.tx_valid || bus.Ack_out || bus.timeout_err) v++;
        end
        chk("t3_wait_low_hold", 64'(v), 64'd0);
        end_req();

        // header-only message, minimum legal length
        start_req(32'h01020304, 16'd4, 32'd0, 8'h00);
        run(0, 100, 0);
        check_stream("t3b");
        chk("t3b_ack_cnt", 64'(ack_cnt), 64'd1);
        end_req();

        // expiry on the final handshake: completion wins
        start_req(32'h01860000, 16'd8, 32'(8 + SOFF), 8'h11);
        run(0, 100, 0);
        check_stream("tsim");
        chk("tsim_ack_cnt", 64'(ack_cnt), 64'd1);
        chk("tsim_tmo_cnt", 64'(tmo_cnt), 64'd0);
        end_req();

        // bad lengths
        start_req(32'h01830000, 16'd2, 32'd0, 8'h00);
        run(0, 50, 0);
        chk("t4a_len_cnt", 64'(len_cnt), 64'd1);
        chk("t4a_valid", 64'(valid_cnt), 64'd0);
        chk("t4a_ack_cnt", 64'(ack_cnt), 64'd0);
        end_req();
        start_req(32'h01830000, 16'(MAXB + 1), 32'd0, 8'h00);
        run(0, 50, 0);
        chk("t4b_len_cnt", 64'(len_cnt), 64'd1);
        chk("t4b_valid", 64'(valid_cnt), 64'd0);
        chk("t4b_ack_cnt", 64'(ack_cnt), 64'd0);
        end_req();

        // reset after the third byte, then a fresh request
        start_req(32'h01830000, 16'd16, 32'd0, 8'h77);
        run(0, 100, 3 + SOFF);
        chk("t5_abort_reached", 64'(finished), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        bus.msg_req = 1'b0;
        @(negedge clk);
        chk("t5_reset_outs", 64'(outs()), 64'd0);
        reset = 1'b0;
        start_req(32'hA1B2C3D4, 16'd12, 32'd0, 8'h3c);
        run(0, 100, 0);
        check_stream("t5");
        chk("t5_ack_cnt", 64'(ack_cnt), 64'd1);
        end_req();

        // long transfers, including the maximum size
        start_req(32'h01830000, 16'd260, 32'd0, 8'hc5);
        run(0, 700, 0);
        check_stream("t6");
        chk("t6_last_pos", 64'(last_pos), 64'(260 + SOFF));
        chk("t6_ack_cnt", 64'(ack_cnt), 64'd1);
        end_req();
        start_req(32'h01830000, 16'(MAXB), 32'd0, 8'h9e);
        run(0, 700, 0);
        check_stream("t7");
        chk("t7_last_byte", 64'(got[got.size() - 1]),
            64'(pat(MAXB - 5, 8'h9e)));
        chk("t7_ack_cnt", 64'(ack_cnt), 64'd1);
        end_req();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
